// File: rtl/adc_stream_packer.sv
// adc_stream_packer: drains a CDC FIFO of packed ADC sample pairs into
// fixed-length AXI4-Stream packets through a 4-entry output buffer.
module adc_stream_packer #(
  parameter int PacketLen = 256,
  parameter int BufDepth  = 4
) (
  input  logic        clk_sys_i,
  input  logic        rst_n_i,
  input  logic        enable_i,
  input  logic        fifo_empty_i,
  input  logic        fifo_full_i,
  input  logic [31:0] fifo_data_i,
  output logic        fifo_rd_en_o,
  output logic [31:0] m_axis_tdata_o,
  output logic        m_axis_tvalid_o,
  output logic        m_axis_tlast_o,
  input  logic        m_axis_tready_i,
  output logic        busy_o,
  output logic        overflow_o,
  output logic [31:0] pkt_count_o
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  localparam logic [15:0] LastIdx = 16'(PacketLen - 1);
  localparam logic [2:0]  RdLimit = 3'(BufDepth - 1);

  state_e      state_q, state_d;
  logic [31:0] buf_q [4];
  logic [1:0]  wr_ptr_q, rd_ptr_q;
  logic [2:0]  occ_q;
  logic        inflight_q;
  logic        armed_q;
  logic [15:0] issue_q, beat_q;
  logic [31:0] pkt_q;
  logic        ovf_q;

  logic rd_en, start, push, pop, last_hs;

  assign push    = inflight_q;
  assign pop     = (occ_q != 3'd0) && m_axis_tready_i;
  assign last_hs = pop && (beat_q == LastIdx);

  // armed_q commits a capture to at least one packet, so a single-cycle
  // enable pulse still yields a full packet instead of an empty RUN.
  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    rd_en   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (enable_i) begin
          state_d = RUN;
          start   = 1'b1;
        end
      end
      RUN: begin
        rd_en = !fifo_empty_i && ((occ_q + 3'(inflight_q)) <= RdLimit) &&
                (enable_i || (issue_q != 16'd0) || armed_q);
        if (!enable_i && (issue_q == 16'd0) && !armed_q) state_d = DRAIN;
      end
      DRAIN: begin
        if (!inflight_q && ((occ_q == 3'd0) || (last_hs && occ_q == 3'd1)))
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= IDLE;
      wr_ptr_q   <= 2'd0;
      rd_ptr_q   <= 2'd0;
      occ_q      <= 3'd0;
      inflight_q <= 1'b0;
      armed_q    <= 1'b0;
      issue_q    <= 16'd0;
      beat_q     <= 16'd0;
      pkt_q      <= 32'd0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      inflight_q <= rd_en;
      if (start) begin
        issue_q <= 16'd0;
        beat_q  <= 16'd0;
        pkt_q   <= 32'd0;
        ovf_q   <= 1'b0;
        armed_q <= 1'b1;
      end else begin
        if (rd_en) begin
          issue_q <= (issue_q == LastIdx) ? 16'd0 : issue_q + 16'd1;
          armed_q <= 1'b0;
        end
        if (pop) beat_q <= (beat_q == LastIdx) ? 16'd0 : beat_q + 16'd1;
        if (last_hs) pkt_q <= pkt_q + 32'd1;
        if (fifo_full_i && (state_q != IDLE)) ovf_q <= 1'b1;
      end
      if (push) wr_ptr_q <= wr_ptr_q + 2'd1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 2'd1;
      occ_q <= occ_q + 3'(push) - 3'(pop);
    end
  end

  // A push always lands in a free slot, never under the head entry, so the
  // presented beat is stable while stalled.
  always_ff @(posedge clk_sys_i) begin
    if (push) buf_q[wr_ptr_q] <= fifo_data_i;
  end

  assign fifo_rd_en_o    = rd_en;
  assign m_axis_tvalid_o = (occ_q != 3'd0);
  assign m_axis_tdata_o  = m_axis_tvalid_o ? buf_q[rd_ptr_q] : 32'd0;
  assign m_axis_tlast_o  = m_axis_tvalid_o && (beat_q == LastIdx);
  assign busy_o          = (state_q != IDLE);
  assign overflow_o      = ovf_q;
  assign pkt_count_o     = pkt_q;

endmodule
